cond_unit_banked: RTL and testbench
===================================

# cond_unit_banked

Parametrised execute-stage condition unit for the pipelined ARM-subset processor, successor to the single-bank condition logic. It evaluates the 4-bit ARM condition field against one of NBANK selectable NZCV flag banks and gates PCSrc/RegWrite/MemWrite. It updates the selected bank's flags per FlagW and honours pipeline stall and flush. It also provides a shadow flag save/restore for exception entry and return, a registered E→M copy of the gated controls, and a saturating counter of squashed instructions.

## Interface
Parameters:
- NBANK, 4, number of NZCV flag banks (≥1); BSW = max(1, $clog2(NBANK))
- CNTW, 16, width of squashed-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold E stage: no state update, registered outputs hold
- flush  in  1  kill instruction in E: combinational gated outputs forced 0, no flag write
- valid  in  1  E-stage instruction valid
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  2  [1]=update NZ, [0]=update CV
- BankSel  in  BSW  flag bank for both evaluation and update; values ≥ NBANK behave as bank 0
- PCS, RegW, MemW  in  1 each  ungated decoder controls
- save  in  1  copy selected bank into shadow register
- restore  in  1  load shadow register into selected bank
- cnt_clr  in  1  clear squash counter
- PCSrc, RegWrite, MemWrite  out  1 each  gated combinational controls
- CondEx  out  1  condition passed (combinational)
- RegWriteM, MemWriteM, PCSrcM  out  1 each  registered gated controls for M stage
- FlagsOut  out  4  current NZCV of selected bank
- squash_cnt  out  CNTW  count of valid instructions that failed their condition

## Operation
- Condition decode on the selected bank {N,Z,C,V}:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1
- act = valid & !flush & CondEx.
- PCSrc = PCS&act; RegWrite = RegW&act; MemWrite = MemW&act.
- Flag write enable: we = act & !stall.
  - FlagW[1]&we: bank[BankSel].NZ <= ALUFlags[3:2].
  - FlagW[0]&we: bank[BankSel].CV <= ALUFlags[1:0].
  - Other banks are never modified.
- save & !stall: shadow <= bank[BankSel], using the pre-update value.
- restore & !stall: bank[BankSel] <= shadow.
  - restore overrides a same-cycle FlagW write to that bank.
  - save and restore in the same cycle swap the two values, with no loss.
- Squash counter: increments when valid & !flush & !stall & !CondEx. It saturates at 2^CNTW−1. cnt_clr has priority over increment; the counter reads 0 the next cycle.
- M-stage registers:
  - !stall: RegWriteM/MemWriteM/PCSrcM <= RegWrite/MemWrite/PCSrc.
  - stall: hold.
  - Because of flush gating, a flushed instruction loads zeros.

## Timing
- Reset value of every register is 0: all banks, shadow, squash_cnt, RegWriteM, MemWriteM, PCSrcM.
- After reset, FlagsOut = 0000, and CondEx for EQ=0, NE=1, AL=1.
- CondEx, PCSrc, RegWrite, MemWrite and FlagsOut are combinational from the current state and inputs, with zero latency.
- A flag update is visible to CondEx/FlagsOut on the cycle after the writing instruction. An instruction never sees its own ALUFlags.
- M-stage outputs lag the E-stage gated controls by exactly 1 cycle (more while stalled).
- reset has priority over stall, flush, save, restore and cnt_clr. Asserting reset mid-stall clears everything on that edge.
- BankSel changes take effect combinationally. Writes target the BankSel sampled at the edge.

## Test plan
- Reset, then Cond=0000, valid=1, RegW=1 → CondEx=0, RegWrite=0. Then Cond=0001 → RegWrite=1, and RegWriteM=1 the next cycle.
- Bank 1: Cond=1110, FlagW=11, ALUFlags=0100 → next cycle with BankSel=1, EQ passes, and FlagsOut=0100. With BankSel=0, FlagsOut=0000 and EQ fails.
- FlagW=10 with ALUFlags=1111 on bank 0 holding 0011 → bank 0 = 1111. Then FlagW=01, ALUFlags=0000 → bank 0 = 1100.
- The same flag-setting instruction under stall=1 or flush=1 → no flag change, PCSrc/RegWrite/MemWrite=0 under flush, and M registers hold under stall.
- Bank 2 = 1001, save → shadow = 1001. Write 0000 to bank 2, then restore → bank 2 = 1001. Restore and FlagW in the same cycle → restore wins.
- CNTW=2: 5 consecutive failing valid instructions → squash_cnt 1,2,3,3,3. cnt_clr with a failing instruction → 0.

Source files
------------

// File: rtl/cond_unit_banked.sv
// Execute-stage condition unit with NBANK selectable NZCV flag banks,
// shadow save/restore, registered M-stage controls and a squash counter.
module cond_unit_banked #(
    parameter int NBANK = 4,
    parameter int CNTW  = 16,
    localparam int BSW  = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic [BSW-1:0]  BankSel,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    input  logic            save,
    input  logic            restore,
    input  logic            cnt_clr,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            CondEx,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            PCSrcM,
    output logic [3:0]      FlagsOut,
    output logic [CNTW-1:0] squash_cnt
);

    logic [3:0]      bank_q [NBANK];
    logic [3:0]      bank_d [NBANK];
    logic [3:0]      shadow_q, shadow_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            rwm_q, rwm_d;
    logic            mwm_q, mwm_d;
    logic            pcm_q, pcm_d;

    logic [BSW-1:0]  sel;
    logic [3:0]      flags;
    logic            n, z, c, v;
    logic            act;
    logic            we;

    // Out-of-range bank selects fold onto bank 0
    always_comb begin
        sel = '0;
        if (int'(BankSel) < NBANK) begin
            sel = BankSel;
        end
    end

    assign flags    = bank_q[sel];
    assign {n, z, c, v} = flags;
    assign FlagsOut = flags;

    // Condition field decode against the selected bank
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end

    assign act      = valid & ~flush & CondEx;
    assign we       = act & ~stall;
    assign PCSrc    = PCS & act;
    assign RegWrite = RegW & act;
    assign MemWrite = MemW & act;

    // Next-state for banks and shadow; restore beats a same-cycle flag write
    always_comb begin
        bank_d   = bank_q;
        shadow_d = shadow_q;
        if (we && FlagW[1]) begin
            bank_d[sel][3:2] = ALUFlags[3:2];
        end
        if (we && FlagW[0]) begin
            bank_d[sel][1:0] = ALUFlags[1:0];
        end
        if (save && !stall) begin
            shadow_d = bank_q[sel];
        end
        if (restore && !stall) begin
            bank_d[sel] = shadow_q;
        end
    end

    // Saturating squash counter; clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (valid && !flush && !CondEx && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // M-stage copies of gated controls, frozen while stalled
    always_comb begin
        rwm_d = rwm_q;
        mwm_d = mwm_q;
        pcm_d = pcm_q;
        if (!stall) begin
            rwm_d = RegWrite;
            mwm_d = MemWrite;
            pcm_d = PCSrc;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= '0;
            end
            shadow_q <= '0;
            cnt_q    <= '0;
            rwm_q    <= 1'b0;
            mwm_q    <= 1'b0;
            pcm_q    <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            rwm_q    <= rwm_d;
            mwm_q    <= mwm_d;
            pcm_q    <= pcm_d;
        end
    end

    assign RegWriteM  = rwm_q;
    assign MemWriteM  = mwm_q;
    assign PCSrcM     = pcm_q;
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_cond_unit_banked.sv
// Directed bench for cond_unit_banked (NBANK=4, CNTW=2).
// Table of per-cycle vectors plus hand sequences for counter, decode, reset.
module tb_cond_unit_banked;

    logic       clk = 1'b0;
    logic       reset, stall, flush, valid;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW, BankSel;
    logic       PCS, RegW, MemW, save, restore, cnt_clr;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic       RegWriteM, MemWriteM, PCSrcM;
    logic [3:0] FlagsOut;
    logic [1:0] squash_cnt;

    int checks = 0;
    int failures = 0;
    int cur = 0;

    always #5 clk = ~clk;

    cond_unit_banked #(.NBANK(4), .CNTW(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid(valid), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .BankSel(BankSel), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .save(save), .restore(restore), .cnt_clr(cnt_clr),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .FlagsOut(FlagsOut), .squash_cnt(squash_cnt)
    );

    typedef struct {
        logic       vld, fl, st;
        logic [3:0] cond, alu;
        logic [1:0] fw, bs;
        logic       pcs, rw, mw, sv, rs, clr;
        logic       ex, pcsrc, regw, memw;
        logic [3:0] fo;
        logic       rwm, mwm, pcm;
        logic [1:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic vld, fl, st, input logic [3:0] cond, alu,
        input logic [1:0] fw, bs, input logic pcs, rw, mw, sv, rs, clr,
        input logic ex, pcsrc, regw, memw, input logic [3:0] fo,
        input logic rwm, mwm, pcm, input logic [1:0] cnt);
        vec_t r;
        r.vld = vld; r.fl = fl; r.st = st; r.cond = cond; r.alu = alu;
        r.fw = fw; r.bs = bs; r.pcs = pcs; r.rw = rw; r.mw = mw;
        r.sv = sv; r.rs = rs; r.clr = clr; r.ex = ex; r.pcsrc = pcsrc;
        r.regw = regw; r.memw = memw; r.fo = fo; r.rwm = rwm;
        r.mwm = mwm; r.pcm = pcm; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h",
                     nm, cur, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; valid = 0; Cond = 4'b1110;
        ALUFlags = 0; FlagW = 0; BankSel = 0; PCS = 0; RegW = 0;
        MemW = 0; save = 0; restore = 0; cnt_clr = 0;
    endtask

    initial begin
        logic [15:0] m0, m1, m2, got;
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;

        // vld fl st cond alu fw bs pcs rw mw sv rs clr | ex pc rw mw fo rwm mwm pcm cnt
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,0,0,1,0,0,0,0, 0,0,0,0,4'b0000,0,0,0,0));
        vt.push_back(mk(1,0,0,4'b0001,4'b0000,2'b00,0,0,1,0,0,0,0, 1,0,1,0,4'b0000,0,0,0,1));
        vt.push_back(mk(1,0,0,4'b1110,4'b0100,2'b11,1,1,0,0,0,0,0, 1,1,0,0,4'b0000,1,0,0,1));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,1,0,0,1,0,0,0, 1,0,0,1,4'b0100,0,0,1,1));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,0,0,0,1,0,0,0, 0,0,0,0,4'b0000,0,1,0,1));
        vt.push_back(mk(1,0,0,4'b1110,4'b0011,2'b11,0,0,0,0,0,0,0, 1,0,0,0,4'b0000,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b1111,2'b10,0,0,0,0,0,0,0, 1,0,0,0,4'b0011,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b0000,2'b01,0,0,0,0,0,0,0, 1,0,0,0,4'b1111,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1101,4'b0000,2'b00,0,0,1,0,0,0,0, 1,0,1,0,4'b1100,0,0,0,2));
        vt.push_back(mk(1,0,1,4'b1110,4'b0011,2'b11,0,1,1,1,0,0,0, 1,1,1,1,4'b1100,1,0,0,2));
        vt.push_back(mk(1,1,0,4'b1110,4'b0011,2'b11,0,1,1,1,0,0,0, 1,0,0,0,4'b1100,1,0,0,2));
        vt.push_back(mk(0,0,0,4'b0001,4'b0000,2'b00,0,0,0,0,0,0,0, 0,0,0,0,4'b1100,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b1001,2'b11,2,0,0,0,0,0,0, 1,0,0,0,4'b0000,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,2,0,0,0,1,0,0, 1,0,0,0,4'b1001,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b0000,2'b11,2,0,0,0,0,0,0, 1,0,0,0,4'b1001,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,2,0,0,0,0,1,0, 1,0,0,0,4'b0000,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b0110,2'b11,2,0,0,0,0,1,0, 1,0,0,0,4'b1001,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b1110,4'b0011,2'b11,2,0,0,0,0,0,0, 1,0,0,0,4'b1001,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,2,0,0,0,1,1,0, 1,0,0,0,4'b0011,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,2,0,0,0,0,1,0, 1,0,0,0,4'b1001,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,2,0,0,0,0,0,0, 1,0,0,0,4'b0011,0,0,0,2));
        vt.push_back(mk(0,0,0,4'b1110,4'b0000,2'b00,3,0,0,0,0,0,0, 1,0,0,0,4'b0000,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,3,0,0,0,0,0,0, 0,0,0,0,4'b0000,0,0,0,2));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,3,0,0,0,0,0,0, 0,0,0,0,4'b0000,0,0,0,3));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,3,0,0,0,0,0,0, 0,0,0,0,4'b0000,0,0,0,3));
        vt.push_back(mk(1,0,0,4'b0000,4'b0000,2'b00,3,0,0,0,0,0,1, 0,0,0,0,4'b0000,0,0,0,3));
        vt.push_back(mk(0,0,0,4'b0000,4'b0000,2'b00,3,0,0,0,0,0,0, 0,0,0,0,4'b0000,0,0,0,0));

        foreach (vt[i]) begin
            cur = i;
            valid = vt[i].vld; flush = vt[i].fl; stall = vt[i].st;
            Cond = vt[i].cond; ALUFlags = vt[i].alu; FlagW = vt[i].fw;
            BankSel = vt[i].bs; PCS = vt[i].pcs; RegW = vt[i].rw;
            MemW = vt[i].mw; save = vt[i].sv; restore = vt[i].rs;
            cnt_clr = vt[i].clr;
            #1;
            chk("CondEx", 16'(CondEx), 16'(vt[i].ex));
            chk("PCSrc", 16'(PCSrc), 16'(vt[i].pcsrc));
            chk("RegWrite", 16'(RegWrite), 16'(vt[i].regw));
            chk("MemWrite", 16'(MemWrite), 16'(vt[i].memw));
            chk("FlagsOut", 16'(FlagsOut), 16'(vt[i].fo));
            chk("RegWriteM", 16'(RegWriteM), 16'(vt[i].rwm));
            chk("MemWriteM", 16'(MemWriteM), 16'(vt[i].mwm));
            chk("PCSrcM", 16'(PCSrcM), 16'(vt[i].pcm));
            chk("squash_cnt", 16'(squash_cnt), 16'(vt[i].cnt));
            @(negedge clk);
        end

        // Counter counts 1,2,3 then saturates; clear wins over a failing instr
        cur = 100;
        idle();
        valid = 1; Cond = 4'b0000; BankSel = 3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("sat_cnt", 16'(squash_cnt), 16'((k < 3) ? k + 1 : 3));
        end
        @(negedge clk);
        cnt_clr = 1;
        @(posedge clk); #1;
        chk("cnt_clr", 16'(squash_cnt), 16'd0);

        // Full decode sweep on banks 0 (1100), 1 (0100), 2 (0011)
        @(negedge clk);
        idle();
        m0 = 16'hEA99; m1 = 16'hE6A9; m2 = 16'hE966;
        for (int b = 0; b < 3; b++) begin
            got = '0;
            BankSel = 2'(b);
            for (int cc = 0; cc < 16; cc++) begin
                Cond = 4'(cc);
                #1;
                got[cc] = CondEx;
            end
            cur = 200 + b;
            chk("decode", got, (b == 0) ? m0 : (b == 1) ? m1 : m2);
        end

        // Reset asserted during a stall clears everything on that edge
        @(negedge clk);
        idle();
        valid = 1; RegW = 1; MemW = 1; PCS = 1;
        @(negedge clk);
        cur = 300;
        chk("pre_rst_M", 16'({RegWriteM, MemWriteM, PCSrcM}), 16'b111);
        stall = 1; reset = 1;
        @(negedge clk);
        reset = 0;
        idle();
        for (int b = 0; b < 4; b++) begin
            BankSel = 2'(b);
            #1;
            cur = 310 + b;
            chk("rst_bank", 16'(FlagsOut), 16'd0);
        end
        chk("rst_M", 16'({RegWriteM, MemWriteM, PCSrcM}), 16'd0);
        chk("rst_cnt", 16'(squash_cnt), 16'd0);
        BankSel = 2;
        restore = 1;
        @(negedge clk);
        restore = 0;
        #1;
        chk("rst_shadow", 16'(FlagsOut), 16'd0);
        Cond = 4'b0000; #1;
        chk("rst_EQ", 16'(CondEx), 16'd0);
        Cond = 4'b0001; #1;
        chk("rst_NE", 16'(CondEx), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
